// File: rtl/tree_upmerge_node.sv
`default_nettype none
// ============================================================================
// Module   : tree_upmerge_node
// Purpose  : Child-to-parent merge node of the instance tree. Two child
//            valid/ready ports each feed a 2-entry skid FIFO; a round-robin
//            arbiter picks one head per cycle, stamps the winning child index
//            into route bit LEVEL and loads a registered parent port.
// Ports    : clk, rst (sync, active-high)
//            c0_* / c1_*  : child packet inputs (valid, ready, data, path)
//            p_*          : registered parent packet output (valid, ready,
//                           data, path)
//            fwd_cnt0/1   : wrapping 16-bit count of packets forwarded from
//                           each child
// Revision : 1.0 - initial release
// ============================================================================
module tree_upmerge_node #(
  parameter int DATA_W = 32,
  parameter int PATH_W = 20,
  parameter int LEVEL  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_valid,
  output logic              c0_ready,
  input  logic [DATA_W-1:0] c0_data,
  input  logic [PATH_W-1:0] c0_path,
  input  logic              c1_valid,
  output logic              c1_ready,
  input  logic [DATA_W-1:0] c1_data,
  input  logic [PATH_W-1:0] c1_path,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [DATA_W-1:0] p_data,
  output logic [PATH_W-1:0] p_path,
  output logic [15:0]       fwd_cnt0,
  output logic [15:0]       fwd_cnt1
);

  localparam logic [PATH_W-1:0] C_LVL_MASK = PATH_W'(1) << LEVEL;

  // Per-child views so both FIFOs come from one generate body
  logic [1:0]        w_in_valid;
  logic [DATA_W-1:0] w_in_data [2];
  logic [PATH_W-1:0] w_in_path [2];
  logic [1:0]        w_ready;
  logic [1:0]        w_ne;
  logic [1:0]        w_pop;
  logic [DATA_W-1:0] w_head_data [2];
  logic [PATH_W-1:0] w_head_path [2];

  assign w_in_valid   = {c1_valid, c0_valid};
  assign w_in_data[0] = c0_data;
  assign w_in_data[1] = c1_data;
  assign w_in_path[0] = c0_path;
  assign w_in_path[1] = c1_path;
  assign c0_ready     = w_ready[0];
  assign c1_ready     = w_ready[1];

  for (genvar g = 0; g < 2; g++) begin : g_child
    logic [DATA_W-1:0] r_mem_data [2];
    logic [PATH_W-1:0] r_mem_path [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;
    logic              w_wr;

    // Ready is derived from registered occupancy only, so a same-cycle pop
    // never lets a full FIFO accept.
    assign w_ready[g]     = (r_occ < 2'd2);
    assign w_wr           = w_in_valid[g] && w_ready[g];
    assign w_ne[g]        = (r_occ != 2'd0);
    assign w_head_data[g] = r_mem_data[r_rptr];
    assign w_head_path[g] = r_mem_path[r_rptr];

    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem_data[r_wptr] <= w_in_data[g];
        r_mem_path[r_wptr] <= w_in_path[g];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
        r_occ  <= 2'd0;
      end else begin
        if (w_wr) begin
          r_wptr <= ~r_wptr;
        end
        if (w_pop[g]) begin
          r_rptr <= ~r_rptr;
        end
        case ({w_wr, w_pop[g]})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // Arbitration
  logic              r_rr;
  logic              r_p_valid;
  logic [DATA_W-1:0] r_p_data;
  logic [PATH_W-1:0] r_p_path;
  logic [15:0]       r_cnt0;
  logic [15:0]       r_cnt1;

  logic              w_can_load;
  logic              w_grant;
  logic              w_gidx;
  logic [DATA_W-1:0] w_sel_data;
  logic [PATH_W-1:0] w_sel_path;
  logic [PATH_W-1:0] w_stamped;

  assign w_can_load = !r_p_valid || p_ready;

  always_comb begin
    w_grant = 1'b0;
    w_gidx  = 1'b0;
    if (w_can_load) begin
      if (w_ne[0] && w_ne[1]) begin
        w_grant = 1'b1;
        w_gidx  = r_rr;
      end else if (w_ne[0]) begin
        w_grant = 1'b1;
        w_gidx  = 1'b0;
      end else if (w_ne[1]) begin
        w_grant = 1'b1;
        w_gidx  = 1'b1;
      end
    end
  end

  assign w_pop      = {w_grant && w_gidx, w_grant && !w_gidx};
  assign w_sel_data = w_gidx ? w_head_data[1] : w_head_data[0];
  assign w_sel_path = w_gidx ? w_head_path[1] : w_head_path[0];
  // Replace only this node's route bit with the winning child index
  assign w_stamped  = (w_sel_path & ~C_LVL_MASK) | ({PATH_W{w_gidx}} & C_LVL_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_p_valid <= 1'b0;
      r_p_data  <= '0;
      r_p_path  <= '0;
      r_cnt0    <= 16'd0;
      r_cnt1    <= 16'd0;
    end else if (w_can_load) begin
      r_p_valid <= w_grant;
      if (w_grant) begin
        r_p_data <= w_sel_data;
        r_p_path <= w_stamped;
        r_rr     <= ~w_gidx;
        if (w_gidx) begin
          r_cnt1 <= r_cnt1 + 16'd1;
        end else begin
          r_cnt0 <= r_cnt0 + 16'd1;
        end
      end
    end
  end

  assign p_valid  = r_p_valid;
  assign p_data   = r_p_data;
  assign p_path   = r_p_path;
  assign fwd_cnt0 = r_cnt0;
  assign fwd_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_tree_upmerge_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_upmerge_node
// Purpose  : Self-checking bench for tree_upmerge_node (LEVEL = 3). Per-child
//            scoreboard queues are filled when a child handshake is seen and
//            drained when the parent handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tree_upmerge_node;

  localparam int DATA_W = 32;
  localparam int PATH_W = 20;
  localparam int LEVEL  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              c0_valid, c0_ready, c1_valid, c1_ready;
  logic [DATA_W-1:0] c0_data, c1_data, p_data;
  logic [PATH_W-1:0] c0_path, c1_path, p_path;
  logic              p_valid, p_ready;
  logic [15:0]       fwd_cnt0, fwd_cnt1;

  tree_upmerge_node #(.DATA_W(DATA_W), .PATH_W(PATH_W), .LEVEL(LEVEL)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_data(c0_data), .c0_path(c0_path),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_data(c1_data), .c1_path(c1_path),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data), .p_path(p_path),
    .fwd_cnt0(fwd_cnt0), .fwd_cnt1(fwd_cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PATH_W-1:0] stamp(input logic [PATH_W-1:0] p, input logic c);
    logic [PATH_W-1:0] m;
    m = PATH_W'(1) << LEVEL;
    return (p & ~m) | (c ? m : '0);
  endfunction

  // Scoreboard: expected {data, path} per child
  logic [DATA_W+PATH_W-1:0] q0[$];
  logic [DATA_W+PATH_W-1:0] q1[$];
  logic                     seq[$];
  bit                       acc0, acc1;
  int                       n_out = 0;
  int                       n_acc = 0;

  // Handshakes seen here complete on the following rising edge
  always @(negedge clk) begin
    logic [DATA_W+PATH_W-1:0] e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (c0_valid && c0_ready) begin
        q0.push_back({c0_data, stamp(c0_path, 1'b0)});
        acc0 = 1'b1;
        n_acc++;
      end
      if (c1_valid && c1_ready) begin
        q1.push_back({c1_data, stamp(c1_path, 1'b1)});
        acc1 = 1'b1;
        n_acc++;
      end
      if (p_valid && p_ready) begin
        n_out++;
        seq.push_back(p_path[LEVEL]);
        if (p_path[LEVEL] ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk("spurious_output", 64'({p_data, p_path}), 64'(0));
        end else begin
          e = p_path[LEVEL] ? q1.pop_front() : q0.pop_front();
          chk("pkt", 64'({p_data, p_path}), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic run_stream(input int n0, input int n1, input int budget);
    int  s0, s1, cyc;
    bit  done;
    s0 = 0; s1 = 0; cyc = 0; done = 1'b0;
    c0_data = 32'h0C00_0000; c0_path = 20'($urandom); c0_valid = (n0 > 0);
    c1_data = 32'h1C00_0000; c1_path = 20'($urandom); c1_valid = (n1 > 0);
    while (!done) begin
      tick();
      cyc++;
      if (acc0) begin s0++; c0_data = 32'h0C00_0000 + 32'(s0); c0_path = 20'($urandom); end
      if (acc1) begin s1++; c1_data = 32'h1C00_0000 + 32'(s1); c1_path = 20'($urandom); end
      c0_valid = (s0 < n0);
      c1_valid = (s1 < n1);
      if (s0 >= n0 && s1 >= n1 && q0.size() == 0 && q1.size() == 0 && !p_valid) begin
        done = 1'b1;
      end else if (cyc >= budget) begin
        chk("stream_timeout", 64'(cyc), 64'(0));
        done = 1'b1;
      end
    end
    c0_valid = 1'b0;
    c1_valid = 1'b0;
  endtask

  typedef struct {
    logic              child;
    logic [DATA_W-1:0] data;
    logic [PATH_W-1:0] path;
    logic [PATH_W-1:0] exp_path;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DATA_W-1:0] cap;
    bit                have;
    int                exp_cnt[2];
    int                base_acc, base_out, cyc;

    vecs[0] = '{1'b1, 32'hA5A5_0001, 20'h00000, 20'h00008};
    vecs[1] = '{1'b0, 32'h1234_5678, 20'hFFFFF, 20'hFFFF7};
    vecs[2] = '{1'b1, 32'hDEAD_BEEF, 20'h00008, 20'h00008};
    vecs[3] = '{1'b0, 32'h0000_0000, 20'h00008, 20'h00000};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 20'h55555, 20'h5555D};
    vecs[5] = '{1'b0, 32'h5555_5555, 20'hAAAAA, 20'hAAAA2};

    rst = 1'b1; p_ready = 1'b1;
    c0_valid = 1'b0; c0_data = '0; c0_path = '0;
    c1_valid = 1'b0; c1_data = '0; c1_path = '0;

    // Post-reset state
    do_reset();
    @(negedge clk);
    chk("rst_p_valid", 64'(p_valid), 64'(0));
    chk("rst_c0_ready", 64'(c0_ready), 64'(1));
    chk("rst_c1_ready", 64'(c1_ready), 64'(1));
    chk("rst_cnt0", 64'(fwd_cnt0), 64'(0));
    chk("rst_cnt1", 64'(fwd_cnt1), 64'(0));
    chk("rst_p_data", 64'(p_data), 64'(0));
    chk("rst_p_path", 64'(p_path), 64'(0));

    // Single-packet vectors: latency, stamping, counters
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vecs[i].child) begin
        c1_valid = 1'b1; c1_data = vecs[i].data; c1_path = vecs[i].path;
      end else begin
        c0_valid = 1'b1; c0_data = vecs[i].data; c0_path = vecs[i].path;
      end
      exp_cnt[vecs[i].child]++;
      tick();
      c0_valid = 1'b0; c1_valid = 1'b0;
      chk("vec_not_early", 64'(p_valid), 64'(0));
      tick();
      chk("vec_p_valid", 64'(p_valid), 64'(1));
      chk("vec_p_data", 64'(p_data), 64'(vecs[i].data));
      chk("vec_p_path", 64'(p_path), 64'(vecs[i].exp_path));
      chk("vec_cnt0", 64'(fwd_cnt0), 64'(exp_cnt[0]));
      chk("vec_cnt1", 64'(fwd_cnt1), 64'(exp_cnt[1]));
      tick();
      chk("vec_drained", 64'(p_valid), 64'(0));
    end

    // Contention: 8 + 8 packets, strict alternation from child 0
    do_reset();
    seq.delete();
    p_ready = 1'b1;
    run_stream(8, 8, 200);
    chk("cont_count", 64'(seq.size()), 64'(16));
    for (int i = 0; i < 16 && i < seq.size(); i++) begin
      chk("cont_order", 64'(seq[i]), 64'(i % 2));
    end
    chk("cont_cnt0", 64'(fwd_cnt0), 64'(8));
    chk("cont_cnt1", 64'(fwd_cnt1), 64'(8));

    // Backpressure: 10 stalled cycles with both children pushing
    tick();
    p_ready = 1'b0;
    base_acc = n_acc;
    have = 1'b0;
    c0_valid = 1'b1; c0_data = 32'h0B00_0000; c0_path = 20'($urandom);
    c1_valid = 1'b1; c1_data = 32'h1B00_0000; c1_path = 20'($urandom);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc0) begin c0_data = c0_data + 32'd1; c0_path = 20'($urandom); end
      if (acc1) begin c1_data = c1_data + 32'd1; c1_path = 20'($urandom); end
      if (p_valid) begin
        if (!have) begin
          cap = p_data;
          have = 1'b1;
        end else begin
          chk("stall_p_data", 64'(p_data), 64'(cap));
        end
      end
    end
    chk("bp_c0_ready", 64'(c0_ready), 64'(0));
    chk("bp_c1_ready", 64'(c1_ready), 64'(0));
    chk("bp_accepted", 64'(n_acc - base_acc), 64'(5));
    base_out = n_out;
    p_ready = 1'b1;
    c0_valid = 1'b0; c1_valid = 1'b0;
    cyc = 0;
    while ((p_valid || q0.size() != 0 || q1.size() != 0) && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("bp_drain_done", 64'(cyc < 30), 64'(1));
    chk("bp_drained", 64'(n_out - base_out), 64'(5));

    // Reset mid-flight with both FIFOs full and output held
    p_ready = 1'b0;
    c0_valid = 1'b1; c0_data = 32'h0DD0_0000;
    c1_valid = 1'b1; c1_data = 32'h1DD0_0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acc0) c0_data = c0_data + 32'd1;
      if (acc1) c1_data = c1_data + 32'd1;
    end
    chk("mid_pre_valid", 64'(p_valid), 64'(1));
    chk("mid_pre_full", 64'({c1_ready, c0_ready}), 64'(0));
    rst = 1'b1;
    c0_valid = 1'b0; c1_valid = 1'b0;
    tick();
    chk("mid_p_valid", 64'(p_valid), 64'(0));
    chk("mid_cnt0", 64'(fwd_cnt0), 64'(0));
    chk("mid_cnt1", 64'(fwd_cnt1), 64'(0));
    chk("mid_ready", 64'({c1_ready, c0_ready}), 64'(3));
    rst = 1'b0;
    p_ready = 1'b1;
    base_out = n_out;
    repeat (10) tick();
    chk("mid_no_stale", 64'(n_out - base_out), 64'(0));

    // Counter wrap on child 0
    run_stream(65537, 0, 70000);
    chk("wrap_cnt0", 64'(fwd_cnt0), 64'(1));
    chk("wrap_cnt1", 64'(fwd_cnt1), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
